// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Multi-cycle WIDTH-bit adder built from a single 4-bit ripple slice.
//   - A start request latches a, b and cin.
//   - The slice then processes one nibble per cycle, least significant first.
//   - Each slice carry-out is registered and fed back as the next nibble's carry-in.
//   - The finished result lands on sum/cout in one step, with a one-cycle done pulse.
//
//   Optional feature: define SIGNED_OVF_EN to add the ovf output (signed overflow of
//   the latched operands), updated and held together with sum.
//
// Ports
//   clk    in   1      rising-edge clock
//   reset  in   1      asynchronous active-high reset
//   start  in   1      request; accepted in IDLE or DONE, ignored while busy
//   a, b   in   WIDTH  operands, sampled with start
//   cin    in   1      carry-in, sampled with start
//   busy   out  1      high while nibbles are being processed
//   done   out  1      one-cycle pulse, result valid on sum/cout
//   sum    out  WIDTH  registered result, held until the next completion
//   cout   out  1      registered final carry-out
//   ovf    out  1      signed overflow (SIGNED_OVF_EN only)

module four_bit_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   res_q, res_d;
`ifdef SIGNED_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic [3:0] sl_a, sl_b, sl_s;
  logic       sl_co;

  // Slice inputs: the current nibble of each latched operand plus the registered carry
  assign sl_a = opa_q[4*idx_q +: 4];
  assign sl_b = opb_q[4*idx_q +: 4];

  four_bit_adder u_slice (
    .a  (sl_a),
    .b  (sl_b),
    .ci (carry_q),
    .s  (sl_s),
    .co (sl_co)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
`ifdef SIGNED_OVF_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        res_d[4*idx_q +: 4] = sl_s;
        carry_d = sl_co;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          // res_d already holds the final nibble, so sum never shows a partial value
          sum_d   = res_d;
          cout_d  = sl_co;
`ifdef SIGNED_OVF_EN
          ovf_d   = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) && (res_d[WIDTH-1] != opa_q[WIDTH-1]);
`endif
          idx_d   = '0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN);
  end

  // Control and output registers: asynchronously cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SIGNED_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SIGNED_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Operand and partial-result registers: no reset, always written before being read
  always_ff @(posedge clk) begin
    opa_q <= opa_d;
    opb_q <= opb_d;
    res_q <= res_d;
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SIGNED_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
